// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the tick divider bank.
package clkdiv_pkg;

  // Smallest legal divisor; a divisor of zero is rejected at the config port.
  localparam int DIV_MIN = 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_e;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, divisor/cascade registers, tick and sq outputs.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = 27,
  parameter int DEF_DIV  = 1000,
  parameter bit DEF_CASC = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             load_casc,
  output logic             wrap,
  output logic             tick,
  output logic             sq,
  output logic             casc
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;

  // The event that completes the current period.
  assign wrap = ev && (cnt == div - CNT_W'(DIV_MIN));

  // Count events; a load restarts the period but lets the old period's tick through.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      div  <= CNT_W'(DEF_DIV);
      casc <= DEF_CASC;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) sq <= ~sq;
      if (load) begin
        cnt  <= '0;
        div  <= load_div;
        casc <= load_casc;
      end else if (wrap) begin
        cnt <= '0;
      end else if (ev) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tick_divider_bank.sv
// Multi-channel programmable tick divider with optional cascading and a
// glitch-free config port (new ratios land only on a period boundary or
// while the target is stopped).
module tick_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                CNT_W        = 27,
  parameter int                DEF_DIV      = 1000,
  parameter logic [NUM_CH-1:0] CASCADE_INIT = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             en,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
  input  logic                          cfg_cascade,
  output logic                          cfg_err,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             sq
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  cfg_state_e       state;
  logic [CH_W-1:0]  slot_ch;
  logic [CNT_W-1:0] slot_div;
  logic             slot_casc;

  logic [NUM_CH-1:0] ev, wrap, load, casc;
  logic [CH_W:0]     ch_ext;
  logic              cfg_bad;

  assign cfg_ready = (state == IDLE);
  assign ch_ext    = {1'b0, cfg_ch};
  assign cfg_bad   = (cfg_div == '0) || (ch_ext >= (CH_W+1)'(NUM_CH));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic src;
    if (k == 0) begin : g_src0
      // casc[0] is pinned low, so channel 0 always counts clk.
      assign src = ~casc[0];
    end else begin : g_srcn
      assign src = casc[k] ? tick[k-1] : 1'b1;
    end

    assign ev[k]   = en[k] && src;
    // Apply the pending write on the target's wrap edge, or at once if it is stopped.
    assign load[k] = (state == PENDING) && (slot_ch == CH_W'(k)) && (wrap[k] || !en[k]);

    clkdiv_channel #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .DEF_CASC ((k == 0) ? 1'b0 : CASCADE_INIT[k])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ev        (ev[k]),
      .load      (load[k]),
      .load_div  (slot_div),
      .load_casc ((k == 0) ? 1'b0 : slot_casc),
      .wrap      (wrap[k]),
      .tick      (tick[k]),
      .sq        (sq[k]),
      .casc      (casc[k])
    );
  end

  // Config FSM: validate and capture a request, then wait for the apply point.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot_ch   <= '0;
      slot_div  <= '0;
      slot_casc <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              slot_ch   <= cfg_ch;
              slot_div  <= cfg_div;
              slot_casc <= cfg_cascade;
              state     <= PENDING;
            end
          end
        end
        PENDING: if (|load) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed bench for tick_divider_bank: expectations are queued per cycle as
// stimulus is driven and compared after each clock edge.
module tb_tick_divider_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_cascade;
  logic       cfg_err;
  logic [2:0] tick;
  logic [2:0] sq;

  always #5 clk = ~clk;

  tick_divider_bank #(
    .NUM_CH       (3),
    .CNT_W        (8),
    .DEF_DIV      (3),
    .CASCADE_INIT (3'b000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_cascade (cfg_cascade),
    .cfg_err     (cfg_err),
    .tick        (tick),
    .sq          (sq)
  );

  typedef struct {
    string      tag;
    logic [2:0] tick;
    logic [2:0] sq;
    logic [2:0] sqm;
    logic       rdy_chk;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input string tag, input logic [2:0] t, input logic [2:0] s,
                      input logic [2:0] sm, input logic rc, input logic r, input logic e);
    exp_t x;
    x.tag = tag; x.tick = t; x.sq = s; x.sqm = sm;
    x.rdy_chk = rc; x.rdy = r; x.err = e;
    sb.push_back(x);
  endtask

  task automatic check_one();
    exp_t x;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: got empty queue, want an entry");
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      assert (tick === x.tick) else begin
        errors++;
        $error("FAIL %s tick: got %b want %b", x.tag, tick, x.tick);
      end
      checks++;
      assert (cfg_err === x.err) else begin
        errors++;
        $error("FAIL %s cfg_err: got %b want %b", x.tag, cfg_err, x.err);
      end
      if (x.sqm != 3'b000) begin
        checks++;
        assert ((sq & x.sqm) === (x.sq & x.sqm)) else begin
          errors++;
          $error("FAIL %s sq: got %b want %b (mask %b)", x.tag, sq, x.sq, x.sqm);
        end
      end
      if (x.rdy_chk) begin
        checks++;
        assert (cfg_ready === x.rdy) else begin
          errors++;
          $error("FAIL %s cfg_ready: got %b want %b", x.tag, cfg_ready, x.rdy);
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_one();
    end
  endtask

  // Config write while all channels are stopped: one PENDING cycle, then idle.
  task automatic cfg_quiet(input logic [1:0] ch, input logic [7:0] dv, input logic cs,
                           input string tag);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_cascade = cs;
    push({tag, " pend"}, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    run(1);
    cfg_valid = 1'b0;
    push({tag, " done"}, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    run(1);
  endtask

  initial begin
    rst = 1'b1; en = 3'b000; cfg_valid = 1'b0;
    cfg_ch = 2'd0; cfg_div = 8'd0; cfg_cascade = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // A: default divisor 3 on channel 0, reset state at cycle 0.
    rst = 1'b0; en = 3'b001;
    push("A c0 reset", 3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0);
    check_one();
    for (int c = 1; c <= 9; c++)
      push($sformatf("A c%0d", c), (c % 3 == 0) ? 3'b001 : 3'b000,
           {2'b00, 1'((c / 3) % 2)}, 3'b111, 1'b1, 1'b1, 1'b0);
    run(9);

    // B: ch0 div=4, ch1 cascaded div=3.
    en = 3'b000;
    cfg_quiet(2'd0, 8'd4, 1'b0, "B cfg0");
    cfg_quiet(2'd1, 8'd3, 1'b1, "B cfg1");
    en = 3'b011;
    for (int c = 1; c <= 25; c++) begin
      logic t0, t1, s0, s1;
      t0 = (c % 4 == 0);
      t1 = (c == 13) || (c == 25);
      s0 = 1'b1 ^ 1'((c / 4) % 2);
      s1 = (c >= 13) && (c < 25);
      push($sformatf("B c%0d", c), {1'b0, t1, t0}, {1'b0, s1, s0}, 3'b011, 1'b1, 1'b1, 1'b0);
    end
    run(25);

    // C: ch0 div=10, rewrite to div=5 mid-period.
    en = 3'b000;
    cfg_quiet(2'd0, 8'd10, 1'b0, "C cfg");
    en = 3'b001;
    for (int c = 1; c <= 4; c++)
      push($sformatf("C c%0d", c), 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    run(4);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5; cfg_cascade = 1'b0;
    push("C c5", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    run(1);
    cfg_valid = 1'b0;
    for (int c = 6; c <= 20; c++)
      push($sformatf("C c%0d", c), (c == 10 || c == 15 || c == 20) ? 3'b001 : 3'b000,
           3'b000, 3'b000, (c != 10), (c > 10), 1'b0);
    run(15);

    // D: rejected requests (zero divisor, out-of-range channel).
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
    push("D c21 div0", 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1);
    run(1);
    cfg_valid = 1'b0;
    push("D c22", 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    run(1);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
    push("D c23 badch", 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1);
    run(1);
    cfg_valid = 1'b0;
    for (int c = 24; c <= 30; c++)
      push($sformatf("D c%0d", c), (c % 5 == 0) ? 3'b001 : 3'b000,
           3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    run(7);

    // E: write stopped ch2 div=7, then enable it.
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd7; cfg_cascade = 1'b0;
    push("E c31", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    run(1);
    cfg_valid = 1'b0;
    push("E c32", 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    run(1);
    en = 3'b101;
    for (int c = 33; c <= 40; c++)
      push($sformatf("E c%0d", c), {(c == 39), 1'b0, (c % 5 == 0)},
           {(c >= 39), 2'b00}, 3'b100, 1'b1, 1'b1, 1'b0);
    run(8);

    // F: reset while a write to ch0 is pending, with cfg_valid held through reset.
    push("F c41", 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    push("F c42", 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
    run(2);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
    push("F c43 pend", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    run(1);
    rst = 1'b1;
    push("F rst", 3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0);
    run(1);
    rst = 1'b0; cfg_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      logic s;
      s = 1'((c / 3) % 2);
      push($sformatf("F post c%0d", c), (c % 3 == 0) ? 3'b101 : 3'b000,
           {s, 1'b0, s}, 3'b111, 1'b1, 1'b1, 1'b0);
    end
    run(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
